// File: rtl/cache_ctrl.sv
// MESI cache controller: one set lookup per trace command in an external tag/LRU/MESI
// array, bus traffic for fills, write-backs and upgrades, snoop replies and statistics.
module cache_ctrl #(
  parameter int SETS  = 16384,
  parameter int WAYS  = 8,
  parameter int TAG_W = 12,
  localparam int SW = $clog2(SETS),
  localparam int LW = $clog2(WAYS),
  localparam int LN = TAG_W + LW + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_n,
  input  logic [31:0]        cmd_addr,
  input  logic [1:0]         snoop_res,
  output logic [SW-1:0]      arr_set,
  output logic               arr_rd_en,
  output logic               arr_wr_en,
  input  logic [WAYS*LN-1:0] arr_rd_line,
  output logic [WAYS*LN-1:0] arr_wr_line,
  output logic [2:0]         bus_op,
  output logic               bus_valid,
  output logic [1:0]         snoop_reply,
  output logic               done,
  output logic               hit,
  output logic [31:0]        cnt_rd,
  output logic [31:0]        cnt_wr,
  output logic [31:0]        cnt_hit,
  output logic [31:0]        cnt_miss
);

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, CLEAR} state_t;

  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;
  localparam logic [2:0] BUS_NONE = 3'd0, BUS_READ = 3'd1, BUS_WRITE = 3'd2,
                         BUS_INV = 3'd3, BUS_RWIM = 3'd4;
  localparam logic [1:0] REP_NOHIT = 2'd0, REP_HIT = 2'd1, REP_HITM = 2'd2;
  localparam logic [3:0] CMD_WRITE = 4'd1, CMD_SNP_RD = 4'd3, CMD_SNP_WR = 4'd4,
                         CMD_SNP_RWIM = 4'd5, CMD_SNP_INV = 4'd6, CMD_CLEAR = 4'd8,
                         CMD_PRINT = 4'd9;

  state_t               state_q, state_d;
  logic [3:0]           cmd_q, cmd_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [SW-1:0]        set_q, set_d;
  logic [SW-1:0]        clr_q, clr_d;
  logic                 wb_q, wb_d;
  logic [WAYS*LN-1:0]   lines_q, lines_d;
  logic [31:0]          cnt_rd_q, cnt_rd_d, cnt_wr_q, cnt_wr_d;
  logic [31:0]          cnt_hit_q, cnt_hit_d, cnt_miss_q, cnt_miss_d;

  logic [WAYS*LN-1:0]   lines;
  logic [TAG_W-1:0]     tag_a [WAYS];
  logic [LW-1:0]        lru_a [WAYS];
  logic [1:0]           mesi_a [WAYS];
  logic [TAG_W-1:0]     new_tag [WAYS];
  logic [LW-1:0]        new_lru [WAYS];
  logic [1:0]           new_mesi [WAYS];

  logic                 hit_any, inv_any, is_access;
  logic [LW-1:0]        hit_way, inv_way, lru_way, vic_way, acc_way;

  logic unused_addr;
  assign unused_addr = ^cmd_addr[5:0];

  function automatic logic is_lookup(input logic [3:0] c);
    return (c <= 4'd6) || (c == CMD_PRINT);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // During the extra write-back cycle the array read data is gone, so use the latched copy.
  assign lines = wb_q ? lines_q : arr_rd_line;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign tag_a[gi]  = lines[gi*LN + LW + 2 +: TAG_W];
      assign lru_a[gi]  = lines[gi*LN + 2 +: LW];
      assign mesi_a[gi] = lines[gi*LN +: 2];
      assign arr_wr_line[gi*LN +: LN] = {new_tag[gi], new_lru[gi], new_mesi[gi]};
    end
  endgenerate

  always_comb begin
    hit_any = 1'b0;
    inv_any = 1'b0;
    hit_way = '0;
    inv_way = '0;
    lru_way = '0;
    for (int j = WAYS - 1; j >= 0; j--) begin
      if (mesi_a[j] != ST_I && tag_a[j] == tag_q) begin
        hit_any = 1'b1;
        hit_way = LW'(j);
      end
      if (mesi_a[j] == ST_I) begin
        inv_any = 1'b1;
        inv_way = LW'(j);
      end
      if (lru_a[j] == LW'(WAYS - 1)) lru_way = LW'(j);
    end
    vic_way   = inv_any ? inv_way : lru_way;
    acc_way   = hit_any ? hit_way : vic_way;
    is_access = (cmd_q <= 4'd2);
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    tag_d       = tag_q;
    set_d       = set_q;
    clr_d       = clr_q;
    wb_d        = wb_q;
    lines_d     = lines_q;
    cnt_rd_d    = cnt_rd_q;
    cnt_wr_d    = cnt_wr_q;
    cnt_hit_d   = cnt_hit_q;
    cnt_miss_d  = cnt_miss_q;
    cmd_ready   = 1'b0;
    arr_set     = '0;
    arr_rd_en   = 1'b0;
    arr_wr_en   = 1'b0;
    bus_op      = BUS_NONE;
    snoop_reply = REP_NOHIT;
    done        = 1'b0;
    hit         = 1'b0;
    for (int j = 0; j < WAYS; j++) begin
      new_tag[j]  = '0;
      new_lru[j]  = '0;
      new_mesi[j] = ST_I;
    end

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_d = cmd_n;
          tag_d = cmd_addr[31 -: TAG_W];
          set_d = cmd_addr[6 +: SW];
          clr_d = '0;
          wb_d  = 1'b0;
          if (cmd_n == CMD_CLEAR) begin
            state_d    = CLEAR;
            cnt_rd_d   = '0;
            cnt_wr_d   = '0;
            cnt_hit_d  = '0;
            cnt_miss_d = '0;
          end else if (is_lookup(cmd_n)) begin
            state_d = LOOKUP;
          end else begin
            state_d = UPDATE;
          end
        end
      end

      LOOKUP: begin
        arr_set   = set_q;
        arr_rd_en = 1'b1;
        state_d   = UPDATE;
      end

      UPDATE: begin
        arr_set = set_q;
        for (int j = 0; j < WAYS; j++) begin
          new_tag[j]  = tag_a[j];
          new_lru[j]  = lru_a[j];
          new_mesi[j] = mesi_a[j];
        end
        if (is_access && !hit_any && mesi_a[vic_way] == ST_M && !wb_q) begin
          bus_op  = BUS_WRITE;
          wb_d    = 1'b1;
          lines_d = arr_rd_line;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
          wb_d    = 1'b0;
          if (is_lookup(cmd_q)) hit = hit_any;
          if (is_access) begin
            arr_wr_en = 1'b1;
            // Promote the accessed way to MRU; everything younger than it ages by one.
            for (int j = 0; j < WAYS; j++) begin
              if (lru_a[j] < lru_a[acc_way]) new_lru[j] = lru_a[j] + LW'(1);
            end
            new_lru[acc_way] = '0;
            if (hit_any) begin
              if (cmd_q == CMD_WRITE) begin
                if (mesi_a[acc_way] == ST_S) bus_op = BUS_INV;
                new_mesi[acc_way] = ST_M;
              end
            end else begin
              new_tag[acc_way] = tag_q;
              if (cmd_q == CMD_WRITE) begin
                new_mesi[acc_way] = ST_M;
                bus_op            = BUS_RWIM;
              end else begin
                new_mesi[acc_way] = (snoop_res == REP_NOHIT) ? ST_E : ST_S;
                bus_op            = BUS_READ;
              end
            end
            if (cmd_q == CMD_WRITE) cnt_wr_d = sat_inc(cnt_wr_q);
            else                    cnt_rd_d = sat_inc(cnt_rd_q);
            if (hit_any) cnt_hit_d  = sat_inc(cnt_hit_q);
            else         cnt_miss_d = sat_inc(cnt_miss_q);
          end else if (cmd_q >= CMD_SNP_RD && cmd_q <= CMD_SNP_INV && hit_any) begin
            arr_wr_en   = (cmd_q != CMD_SNP_WR);
            snoop_reply = REP_HIT;
            case (cmd_q)
              CMD_SNP_RD: begin
                if (mesi_a[hit_way] == ST_M) snoop_reply = REP_HITM;
                new_mesi[hit_way] = ST_S;
              end
              CMD_SNP_RWIM: begin
                if (mesi_a[hit_way] == ST_M) snoop_reply = REP_HITM;
                new_mesi[hit_way] = ST_I;
              end
              CMD_SNP_INV: begin
                if (mesi_a[hit_way] == ST_S) new_mesi[hit_way] = ST_I;
              end
              default: ;
            endcase
          end
        end
      end

      CLEAR: begin
        arr_set   = clr_q;
        arr_wr_en = 1'b1;
        for (int j = 0; j < WAYS; j++) new_lru[j] = LW'(j);
        if (clr_q == SW'(SETS - 1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          clr_d = clr_q + SW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
    bus_valid = (bus_op != BUS_NONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      tag_q      <= '0;
      set_q      <= '0;
      clr_q      <= '0;
      wb_q       <= 1'b0;
      lines_q    <= '0;
      cnt_rd_q   <= '0;
      cnt_wr_q   <= '0;
      cnt_hit_q  <= '0;
      cnt_miss_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      tag_q      <= tag_d;
      set_q      <= set_d;
      clr_q      <= clr_d;
      wb_q       <= wb_d;
      lines_q    <= lines_d;
      cnt_rd_q   <= cnt_rd_d;
      cnt_wr_q   <= cnt_wr_d;
      cnt_hit_q  <= cnt_hit_d;
      cnt_miss_q <= cnt_miss_d;
    end
  end

  assign cnt_rd   = cnt_rd_q;
  assign cnt_wr   = cnt_wr_q;
  assign cnt_hit  = cnt_hit_q;
  assign cnt_miss = cnt_miss_q;

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter SETS, default 16384: number of sets; set index width SW = log2(SETS) = 14.
REQ-002 Parameter WAYS, default 8: ways per set; LRU rank width LW = log2(WAYS) = 3.
REQ-003 Parameter TAG_W, default 12: tag width. Address split is tag[31:20], set[19:6], byte offset[5:0].
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 cmd_valid  input  1  trace command present.
REQ-007 cmd_ready  output  1  controller can accept a command.
REQ-008 cmd_n  input  4  command code: 0 read, 1 write, 2 instr read, 3 snoop read, 4 snoop write, 5 snoop RWIM, 6 snoop invalidate, 8 clear, 9 print.
REQ-009 cmd_addr  input  32  command address.
REQ-010 snoop_res  input  2  result of this cache's bus READ: 0 NOHIT, 1 HIT, 2 HITM.
REQ-011 arr_set  output  SW  set index driven to the cache array.
REQ-012 arr_rd_en / arr_wr_en  output  1 each  array read / write strobes.
REQ-013 arr_rd_line  input  WAYS x {tag, LRU, MESI}  lines returned one cycle after arr_rd_en.
REQ-014 arr_wr_line  output  WAYS x {tag, LRU, MESI}  updated lines written when arr_wr_en.
REQ-015 bus_op  output  3  0 none, 1 READ, 2 WRITE, 3 INVALIDATE, 4 RWIM; bus_valid  output  1  qualifies bus_op.
REQ-016 snoop_reply  output  2  0 NOHIT, 1 HIT, 2 HITM, valid with done on commands 3-6.
REQ-017 done  output  1  one-cycle pulse at command completion; hit  output  1  valid with done.
REQ-018 cnt_rd, cnt_wr, cnt_hit, cnt_miss  output  32 each  statistics counters.

Function
REQ-019 The controller SHALL implement FSM states IDLE, LOOKUP, UPDATE, CLEAR.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted when cmd_valid and cmd_ready are both 1 on a clock edge.
REQ-021 An accepted command 0-6 or 9 SHALL go IDLE->LOOKUP, assert arr_rd_en with arr_set = cmd_addr[19:6] in LOOKUP, and go LOOKUP->UPDATE->IDLE.
REQ-022 In UPDATE, hit SHALL be 1 iff some way has MESI != I and a tag equal to cmd_addr[31:20]; done SHALL pulse in UPDATE, which is 2 cycles after acceptance.
REQ-023 LRU rank 0 SHALL denote MRU and WAYS-1 LRU; on an access to way w with rank r, every way with rank < r SHALL increment and w SHALL become 0. Ranks SHALL remain a permutation of 0..WAYS-1.
REQ-024 The victim on a miss SHALL be the lowest-index invalid way, else the way with rank WAYS-1.
REQ-025 Read or instruction-read miss: the victim SHALL get the new tag, and MESI SHALL be E if snoop_res = NOHIT, else S; bus_op SHALL be READ.
REQ-026 A victim in M SHALL produce bus_op WRITE for one cycle, followed in the next cycle by the fill op; UPDATE is extended by that one cycle.
REQ-027 Write miss: the victim SHALL become M with bus_op RWIM. Write hit: S->M with bus_op INVALIDATE; E->M and M->M with no bus op.
REQ-028 Read hit SHALL leave MESI unchanged with no bus op.
REQ-029 Snoop 3: M->S with reply HITM; E->S or S->S with reply HIT. Snoop 5: M->I with reply HITM, otherwise ->I with reply HIT. Snoop 6: S->I with reply HIT. Snoop 4: no change. A snoop miss SHALL reply NOHIT.
REQ-030 Snoops SHALL NOT change LRU; commands 0-2 SHALL always update LRU.
REQ-031 Command 9 SHALL read the set and pulse done without arr_wr_en; other command codes SHALL pulse done one cycle after acceptance with no array access.
REQ-032 Command 8 SHALL enter CLEAR and write set 0..SETS-1, one set per cycle, with way i getting LRU = i, MESI = I and tag = 0. It SHALL zero all counters and pulse done on the cycle of the final write.
REQ-033 cnt_rd SHALL count commands 0 and 2, cnt_wr SHALL count command 1, and cnt_hit / cnt_miss SHALL count hits / misses of commands 0-2; all counters SHALL saturate at 2^32-1.
REQ-034 cmd_n and cmd_addr SHALL be registered at acceptance; input changes after acceptance SHALL have no effect.

Reset
REQ-035 On rst asserted, the FSM SHALL enter IDLE immediately, even mid-CLEAR or mid-UPDATE. All outputs SHALL be 0 except cmd_ready = 1, and counters SHALL be 0. The array SHALL NOT be cleared by rst.

Verification
REQ-036 Sequence: cmd 8, then read 0x0000_1040 with snoop_res NOHIT -> miss; way 0 gets E, tag 0x000; bus READ; cnt_miss = 1.
REQ-037 Sequence: repeat the read, then write the same address -> hit; E->M with no bus op; cnt_hit = 2 and cnt_wr = 1.
REQ-038 Sequence: 9 reads to set 0x041 with tags 0x001..0x009 -> the 9th read evicts the tag-0x001 line; M victim gives bus WRITE then READ.
REQ-039 Sequence: snoop read 3 on an M line -> reply HITM; line becomes S; LRU ranks unchanged.
REQ-040 Sequence: rst pulse 100 cycles into CLEAR -> IDLE the next cycle; cmd_ready = 1; counters 0; done not pulsed.
